// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel types, modes, FSM states and colour constants
package pixel_pkg;
  localparam int PIX_COLOR_W = 16;
  typedef logic [PIX_COLOR_W-1:0] color_t;
  typedef enum logic {MODE_PASS, MODE_FILL} pix_mode_t;
  typedef enum logic {ST_RUN, ST_CLEAR} pwq_state_t;
  localparam color_t COLOR_BLACK = 16'h0000;
  localparam color_t COLOR_BLUE = 16'h001F;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: show-ahead FIFO; when empty the output holds the last popped entry
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW:0] wr_q, rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign dout_o = empty_o ? last_q : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
      last_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        last_q <= mem_q[rd_q[AW-1:0]];
        rd_q <= rd_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: range-checked fragment queue to the framebuffer with a clear sweeper
module pixel_write_queue import pixel_pkg::*; #(
  parameter int ADDR_IN_W = 32,
  parameter int FB_DEPTH = 38400,
  parameter int COLOR_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [COLOR_W-1:0] FILL_COLOR = COLOR_BLUE,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_BLACK,
  localparam int ADDR_W = $clog2(FB_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [ADDR_IN_W-1:0] addr_in,
  input  logic [COLOR_W-1:0]   color_in,
  input  logic                 mode_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 clear_start_in,
  output logic                 busy_out,
  output logic [ADDR_W-1:0]    addr_out,
  output logic [COLOR_W-1:0]   color_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [15:0]          drop_count_out
);
  localparam int W = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
  pwq_state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [15:0] drop_q, drop_d;
  logic full, empty, push, accept, in_range, clearing;
  logic [W-1:0] din, dout;
  always_comb begin
    clearing = state_q == ST_CLEAR;
    ready_out = !clearing && !full;
    busy_out = clearing;
    accept = valid_in && ready_out;
    in_range = addr_in < ADDR_IN_W'(FB_DEPTH);
    push = clearing ? !full : accept && in_range;
    din = clearing ? {clr_q, CLEAR_COLOR}
        : {addr_in[ADDR_W-1:0], pix_mode_t'(mode_in) == MODE_FILL ? FILL_COLOR : color_in};
    drop_d = (accept && !in_range && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    clr_d = (clearing && !full) ? (clr_q == LAST ? '0 : clr_q + 1'b1) : clr_q;
    state_d = clearing ? ((!full && clr_q == LAST) ? ST_RUN : ST_CLEAR)
            : (clear_start_in ? ST_CLEAR : ST_RUN);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= ST_RUN;
      clr_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      drop_q <= drop_d;
    end
  end
  pixel_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_in),
    .rst_n_i(rst_n_in),
    .push_i(push),
    .din_i(din),
    .pop_i(ready_in),
    .dout_o(dout),
    .full_o(full),
    .empty_o(empty)
  );
  assign valid_out = !empty;
  assign {addr_out, color_out} = dout;
  assign drop_count_out = drop_q;
endmodule
